rc4_decrypt_core: RTL and testbench

//  RC4 keystream generator (PRGA) plus decryptor; it runs after the key-schedule shuffle has filled S memory.
//  On start it acquires the S memory and walks it with i/j, swapping entries.
//  For each message byte it produces one keystream byte, XORs it with the encrypted ROM byte and writes the result to the decrypted RAM.

---
 rtl/rc4_pkg.sv | 35 +++
 rtl/rc4_char_check.sv | 11 +
 rtl/rc4_decrypt_core.sv | 160 ++++++++++++++++
 tb/tb_rc4_decrypt_core.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: FSM state encoding, S-memory ownership codes and
// the character-class constants used by the plaintext check.
package rc4_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_SET_I  = 4'd1,
    ST_WAIT_I = 4'd2,
    ST_CAP_I  = 4'd3,
    ST_WAIT_J = 4'd4,
    ST_CAP_J  = 4'd5,
    ST_WR_J   = 4'd6,
    ST_SET_F  = 4'd7,
    ST_WAIT_F = 4'd8,
    ST_CAP_F  = 4'd9,
    ST_NEXT   = 4'd10,
    ST_DONE   = 4'd11
  } rc4_state_e;

  // Who currently drives the shared S memory.
  localparam logic [1:0] MEM_SEL_NONE = 2'b00;
  localparam logic [1:0] MEM_SEL_KSA  = 2'b01;
  localparam logic [1:0] MEM_SEL_PRGA = 2'b10;

  // Accepted plaintext alphabet: lower-case letters and space.
  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_A     = 8'h61;
  localparam logic [7:0] CHAR_Z     = 8'h7A;

  // True when the byte belongs to the accepted alphabet.
  function automatic logic is_text_char(input logic [7:0] b);
    return (b == CHAR_SPACE) || ((b >= CHAR_A) && (b <= CHAR_Z));
  endfunction

endpackage

// File: rtl/rc4_char_check.sv
// Combinational plaintext classifier: ok is high for a-z or space.
module rc4_char_check
  import rc4_pkg::*;
(
  input  logic [7:0] data,
  output logic       ok
);

  assign ok = is_text_char(data);

endmodule

// File: rtl/rc4_decrypt_core.sv
// RC4 PRGA keystream generator and decryptor. Walks the already-shuffled S
// memory with i/j, swaps entries, XORs each keystream byte with the encrypted
// ROM byte and writes the plaintext to RAM. Optionally aborts on the first
// byte outside {a-z, space} so a key search can move on quickly.
module rc4_decrypt_core
  import rc4_pkg::*;
#(
  parameter int         MSG_LEN      = 32,
  parameter int         ADDR_W       = 5,
  parameter bit         CHECK_ASCII  = 1'b1,
  parameter logic [1:0] MEM_SEL_CODE = MEM_SEL_PRGA
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              done,
  output logic              key_valid,
  output logic [1:0]        mem_sel,
  output logic [7:0]        s_addr,
  output logic [7:0]        s_wdata,
  output logic              s_wen,
  input  logic [7:0]        s_q,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_q,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_wen
);

  localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(MSG_LEN - 1);

  rc4_state_e        state_r;
  logic [7:0]        i_r;
  logic [7:0]        j_r;
  logic [7:0]        si_r;
  logic [7:0]        sj_r;
  logic [ADDR_W-1:0] k_r;

  logic [7:0] plain_s;
  logic       char_ok_s;
  logic       reject_s;

  // Plaintext is formed directly from the two memory read ports in CAP_F.
  assign plain_s  = s_q ^ rom_q;
  assign reject_s = CHECK_ASCII && !char_ok_s;

  rc4_char_check u_char_check (
    .data (plain_s),
    .ok   (char_ok_s)
  );

  // Sequencer and datapath: ten states per message byte, all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      i_r       <= 8'd0;
      j_r       <= 8'd0;
      si_r      <= 8'd0;
      sj_r      <= 8'd0;
      k_r       <= '0;
      done      <= 1'b0;
      key_valid <= 1'b0;
      mem_sel   <= MEM_SEL_NONE;
      s_addr    <= 8'd0;
      s_wdata   <= 8'd0;
      s_wen     <= 1'b0;
      rom_addr  <= '0;
      ram_addr  <= '0;
      ram_wdata <= 8'd0;
      ram_wen   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          // DONE releases S memory; a start from either state begins afresh.
          mem_sel <= MEM_SEL_NONE;
          if (start) begin
            i_r       <= 8'd0;
            j_r       <= 8'd0;
            k_r       <= '0;
            done      <= 1'b0;
            key_valid <= 1'b0;
            mem_sel   <= MEM_SEL_CODE;
            state_r   <= ST_SET_I;
          end
        end
        ST_SET_I: begin
          i_r     <= i_r + 8'd1;
          s_addr  <= i_r + 8'd1;
          state_r <= ST_WAIT_I;
        end
        ST_WAIT_I: begin
          state_r <= ST_CAP_I;
        end
        ST_CAP_I: begin
          si_r    <= s_q;
          j_r     <= j_r + s_q;
          s_addr  <= j_r + s_q;
          state_r <= ST_WAIT_J;
        end
        ST_WAIT_J: begin
          state_r <= ST_CAP_J;
        end
        ST_CAP_J: begin
          // First half of the swap: S[i] <= S[j].
          sj_r    <= s_q;
          s_addr  <= i_r;
          s_wdata <= s_q;
          s_wen   <= 1'b1;
          state_r <= ST_WR_J;
        end
        ST_WR_J: begin
          // Second half of the swap: S[j] <= old S[i]. i==j needs no special case.
          s_addr  <= j_r;
          s_wdata <= si_r;
          s_wen   <= 1'b1;
          state_r <= ST_SET_F;
        end
        ST_SET_F: begin
          // The sum is swap-invariant, so pre-swap si/sj give the right index.
          s_wen    <= 1'b0;
          s_addr   <= si_r + sj_r;
          rom_addr <= k_r;
          state_r  <= ST_WAIT_F;
        end
        ST_WAIT_F: begin
          state_r <= ST_CAP_F;
        end
        ST_CAP_F: begin
          if (reject_s) begin
            key_valid <= 1'b0;
            done      <= 1'b1;
            state_r   <= ST_DONE;
          end else begin
            ram_addr  <= k_r;
            ram_wdata <= plain_s;
            ram_wen   <= 1'b1;
            state_r   <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          ram_wen <= 1'b0;
          if (k_r == LAST_K) begin
            key_valid <= 1'b1;
            done      <= 1'b1;
            state_r   <= ST_DONE;
          end else begin
            k_r     <= k_r + ADDR_W'(1);
            state_r <= ST_SET_I;
          end
        end
        default: begin
          s_wen   <= 1'b0;
          ram_wen <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_decrypt_core.sv
// Self-checking bench for rc4_decrypt_core. Three instances cover the short
// checked message, an unchecked message and a long message that wraps i.
// Expected plaintext comes from an RC4 reference model and is queued; each
// RAM write of the active instance pops and compares one entry.
module tb_rc4_decrypt_core;

  logic clk = 1'b0;
  logic rst_n;
  logic load;

  logic [2:0] start_v;
  logic [2:0] done_v;
  logic [2:0] kv_v;
  logic [2:0] s_wen_v;
  logic [2:0] ram_wen_v;
  logic [1:0] mem_sel_v   [3];
  logic [7:0] s_addr_v    [3];
  logic [7:0] s_wdata_v   [3];
  logic [7:0] ram_wdata_v [3];
  logic [8:0] rom_addr_v  [3];
  logic [8:0] ram_addr_v  [3];

  logic [7:0] s_init  [256];
  logic [7:0] rom_img [512];

  // reference model state
  logic [7:0]  m_s  [256];
  logic [7:0]  m_ks [512];
  logic [16:0] exp_q [$];
  logic        exp_kv;
  int          exp_wr;
  int          exp_cyc;

  int n_chk;
  int n_pass;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LEN = (g == 0) ? 2 : ((g == 1) ? 4 : 260);
    localparam int AW  = (g == 2) ? 9 : 5;
    localparam bit CHK = (g == 1) ? 1'b0 : 1'b1;

    logic [AW-1:0] rom_a;
    logic [AW-1:0] ram_a;
    logic [7:0]    s_q;
    logic [7:0]    rom_q;
    logic [7:0]    s_mem   [256];
    logic [7:0]    ram_mem [512];

    rc4_decrypt_core #(
      .MSG_LEN      (LEN),
      .ADDR_W       (AW),
      .CHECK_ASCII  (CHK),
      .MEM_SEL_CODE (2'b10)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start_v[g]),
      .done      (done_v[g]),
      .key_valid (kv_v[g]),
      .mem_sel   (mem_sel_v[g]),
      .s_addr    (s_addr_v[g]),
      .s_wdata   (s_wdata_v[g]),
      .s_wen     (s_wen_v[g]),
      .s_q       (s_q),
      .rom_addr  (rom_a),
      .rom_q     (rom_q),
      .ram_addr  (ram_a),
      .ram_wdata (ram_wdata_v[g]),
      .ram_wen   (ram_wen_v[g])
    );

    assign rom_addr_v[g] = 9'(rom_a);
    assign ram_addr_v[g] = 9'(ram_a);

    // Synchronous memories with one-cycle read latency; load restores S and blanks RAM.
    always @(posedge clk) begin
      s_q   <= s_mem[s_addr_v[g]];
      rom_q <= rom_img[rom_addr_v[g]];
      if (load) begin
        for (int x = 0; x < 256; x++) s_mem[x] <= s_init[x];
        for (int x = 0; x < 512; x++) ram_mem[x] <= 8'hFF;
      end else begin
        if (s_wen_v[g]) s_mem[s_addr_v[g]] <= s_wdata_v[g];
        if (ram_wen_v[g]) ram_mem[ram_addr_v[g]] <= ram_wdata_v[g];
      end
    end
  end

  function automatic logic [7:0] s_at(input int g, input int x);
    case (g)
      0:       return g_dut[0].s_mem[x];
      1:       return g_dut[1].s_mem[x];
      default: return g_dut[2].s_mem[x];
    endcase
  endfunction

  function automatic logic [7:0] ram_at(input int g, input int x);
    case (g)
      0:       return g_dut[0].ram_mem[x];
      1:       return g_dut[1].ram_mem[x];
      default: return g_dut[2].ram_mem[x];
    endcase
  endfunction

  function automatic logic [63:0] outs(input int g);
    return {16'h0, done_v[g], kv_v[g], mem_sel_v[g], s_addr_v[g], s_wdata_v[g], s_wen_v[g],
            rom_addr_v[g], ram_addr_v[g], ram_wdata_v[g], ram_wen_v[g]};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Straight RC4 PRGA over s_init and rom_img; fills exp_q with {addr, plaintext}.
  task automatic model(input int n, input bit chk);
    int i, j;
    logic [7:0] t, ks, b;
    bit stop;
    m_s = s_init;
    exp_q.delete();
    exp_kv = 1'b1; exp_wr = 0; exp_cyc = 10 * n;
    i = 0; j = 0; stop = 1'b0;
    for (int k = 0; k < n && !stop; k++) begin
      i = (i + 1) % 256;
      j = (j + int'(m_s[i])) % 256;
      t = m_s[i]; m_s[i] = m_s[j]; m_s[j] = t;
      ks = m_s[(int'(m_s[i]) + int'(m_s[j])) % 256];
      m_ks[k] = ks;
      b = ks ^ rom_img[k];
      if (chk && !(b == 8'h20 || (b >= 8'h61 && b <= 8'h7A))) begin
        exp_kv = 1'b0; exp_cyc = 10 * k + 9; stop = 1'b1;
      end else begin
        exp_q.push_back({9'(k), b});
        exp_wr++;
      end
    end
  endtask

  task automatic reload();
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
  endtask

  task automatic kick(input int g);
    @(negedge clk); start_v[g] = 1'b1;
    @(negedge clk); start_v[g] = 1'b0;
  endtask

  // Cycle-counted wait for done; pops the scoreboard on every RAM write.
  task automatic watch(input int g, input int rst_at, input int poke_at,
                       output int cyc, output int wr);
    logic [16:0] e;
    wr = 0;
    for (cyc = 1; cyc <= exp_cyc + 20; cyc++) begin
      @(negedge clk);
      start_v[g] = (cyc == poke_at);
      if (ram_wen_v[g]) begin
        wr++;
        if (exp_q.size() == 0) check_eq("extra_ram_write", 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          check_eq("ram_addr", 64'(ram_addr_v[g]), 64'(e[16:8]));
          check_eq("ram_data", 64'(ram_wdata_v[g]), 64'(e[7:0]));
        end
      end
      if (cyc == 5) check_eq("mem_sel_busy", 64'(mem_sel_v[g]), 64'd2);
      if (cyc == rst_at) begin
        rst_n = 1'b0;
        break;
      end
      if (done_v[g]) break;
    end
    start_v[g] = 1'b0;
  endtask

  task automatic finish_run(input int g, input int cyc, input int wr);
    int bad;
    check_eq("done_cycle", 64'(cyc), 64'(exp_cyc));
    check_eq("done", 64'(done_v[g]), 64'd1);
    check_eq("key_valid", 64'(kv_v[g]), 64'(exp_kv));
    check_eq("ram_writes", 64'(wr), 64'(exp_wr));
    check_eq("queue_left", 64'(exp_q.size()), 64'd0);
    bad = 0;
    for (int x = 0; x < 256; x++) if (s_at(g, x) !== m_s[x]) bad++;
    check_eq("s_final", 64'(bad), 64'd0);
    @(negedge clk);
    check_eq("mem_sel_released", 64'(mem_sel_v[g]), 64'd0);
    check_eq("done_held", 64'(done_v[g]), 64'd1);
  endtask

  initial begin
    int cyc, wr, idx;
    logic [7:0] t;
    n_chk = 0; n_pass = 0;
    rst_n = 1'b0; load = 1'b0; start_v = 3'b000;
    for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
    for (int x = 0; x < 512; x++) rom_img[x] = 8'h00;

    // reset state of every instance
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) check_eq("reset_outputs", outs(g), 64'd0);
    rst_n = 1'b1;

    // identity S, two bytes decoding to "aa"
    rom_img[0] = 8'h63; rom_img[1] = 8'h64;
    model(2, 1'b1);
    reload(); kick(0); watch(0, 0, 0, cyc, wr); finish_run(0, cyc, wr);
    check_eq("t1_cycles", 64'(cyc), 64'd20);
    check_eq("t1_ram0", 64'(ram_at(0, 0)), 64'h61);
    check_eq("t1_ram1", 64'(ram_at(0, 1)), 64'h61);

    // second byte decodes to 8'h00 and aborts the run
    rom_img[1] = 8'h05;
    model(2, 1'b1);
    reload(); kick(0); watch(0, 0, 0, cyc, wr); finish_run(0, cyc, wr);
    check_eq("t2_key_valid", 64'(kv_v[0]), 64'd0);
    check_eq("t2_writes", 64'(wr), 64'd1);
    check_eq("t2_ram1_untouched", 64'(ram_at(0, 1)), 64'hFF);

    // unchecked instance: ciphertext equal to keystream gives all-zero plaintext
    for (int k = 0; k < 4; k++) rom_img[k] = 8'h00;
    model(4, 1'b0);
    for (int k = 0; k < 4; k++) rom_img[k] = m_ks[k];
    model(4, 1'b0);
    reload(); kick(1); watch(1, 0, 0, cyc, wr); finish_run(1, cyc, wr);
    for (int k = 0; k < 4; k++) check_eq("t3_ram_zero", 64'(ram_at(1, k)), 64'd0);
    check_eq("t3_key_valid", 64'(kv_v[1]), 64'd1);

    // long message: random permutation with S[1]=1 (i==j at i=1), 260 bytes wrap i
    for (int x = 255; x > 0; x--) begin
      idx = $urandom_range(x, 0);
      t = s_init[x]; s_init[x] = s_init[idx]; s_init[idx] = t;
    end
    idx = 0;
    for (int x = 0; x < 256; x++) if (s_init[x] == 8'd1) idx = x;
    t = s_init[1]; s_init[1] = s_init[idx]; s_init[idx] = t;
    for (int k = 0; k < 260; k++) rom_img[k] = 8'h00;
    model(260, 1'b0);
    for (int k = 0; k < 260; k++)
      rom_img[k] = m_ks[k] ^ ((k % 27 == 26) ? 8'h20 : 8'(8'h61 + (k % 26)));
    model(260, 1'b1);

    // reset during WR_J of byte 3, then a clean rerun
    reload(); kick(2); watch(2, 35, 0, cyc, wr);
    check_eq("t4_reset_point", 64'(cyc), 64'd35);
    @(negedge clk);
    check_eq("t4_reset_outputs", outs(2), 64'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("t4_idle_after_reset", outs(2), 64'd0);
    model(260, 1'b1);
    reload(); kick(2); watch(2, 0, 0, cyc, wr); finish_run(2, cyc, wr);
    check_eq("t5_key_valid", 64'(kv_v[2]), 64'd1);
    check_eq("t5_ram_last", 64'(ram_at(2, 259)), 64'(m_ks[259] ^ rom_img[259]));

    // start pulsed mid-run is ignored; start in DONE reruns cleanly
    for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
    rom_img[0] = 8'h63; rom_img[1] = 8'h64;
    model(2, 1'b1);
    reload(); kick(0); watch(0, 0, 7, cyc, wr); finish_run(0, cyc, wr);
    model(2, 1'b1);
    reload(); kick(0);
    check_eq("t6_done_cleared", 64'(done_v[0]), 64'd0);
    check_eq("t6_mem_sel_taken", 64'(mem_sel_v[0]), 64'd2);
    watch(0, 0, 0, cyc, wr); finish_run(0, cyc, wr);
    check_eq("t6_ram0", 64'(ram_at(0, 0)), 64'h61);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
